// File: rtl/interrupt_ctrl.sv
// Machine-mode interrupt sequencer: arbitrates enabled pending interrupts, drives CSR trap strobes,
// and flushes/redirects fetch on trap entry and mret. Define INTCTRL_VECTORED_EN for vectored mtvec mode.
module interrupt_ctrl #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mstatus_ie_i,
    input  logic                  mie_external_i,
    input  logic                  mie_timer_i,
    input  logic                  mie_software_i,
    input  logic                  mip_external_i,
    input  logic                  mip_timer_i,
    input  logic                  mip_software_i,
    input  logic [DATA_WIDTH-1:0] mtvec_i,
    input  logic [DATA_WIDTH-1:0] mepc_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  pc_valid_i,
    input  logic                  mret_i,
    output logic                  interrupt_type_o,
    output logic                  cause_we_o,
    output logic [3:0]            cause_o,
    output logic                  epc_we_o,
    output logic [DATA_WIDTH-1:0] epc_o,
    output logic                  mstatus_ie_clear_o,
    output logic                  mstatus_ie_set_o,
    output logic                  flush_o,
    output logic                  redirect_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        TRAP,
        JUMP,
        MRET
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cause_q, cause_d;
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
    logic                    ext, sw, tim, take_irq;
    logic [3:0]              win_code;
    logic [DATA_WIDTH-1:0]   trap_base;

    assign ext      = mip_external_i & mie_external_i;
    assign sw       = mip_software_i & mie_software_i;
    assign tim      = mip_timer_i & mie_timer_i;
    assign take_irq = mstatus_ie_i & pc_valid_i & (ext | sw | tim);

    // Fixed priority: external > software > timer.
    always_comb begin
        win_code = 4'd7;
        if (ext) begin
            win_code = 4'd11;
        end else if (sw) begin
            win_code = 4'd3;
        end
    end

    assign trap_base = {mtvec_i[DATA_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cause_q <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE: begin
                if (take_irq) begin
                    state_d = TRAP;
                    cause_d = win_code;
                    pc_d    = pc_i;
                end else if (mret_i && pc_valid_i) begin
                    state_d = MRET;
                end
            end
            TRAP:    state_d = JUMP;
            JUMP:    state_d = IDLE;
            MRET:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifndef INTCTRL_VECTORED_EN
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = &{1'b0, mtvec_i[1:0]};
`endif

    always_comb begin
        interrupt_type_o   = 1'b0;
        cause_we_o         = 1'b0;
        cause_o            = '0;
        epc_we_o           = 1'b0;
        epc_o              = '0;
        mstatus_ie_clear_o = 1'b0;
        mstatus_ie_set_o   = 1'b0;
        flush_o            = 1'b0;
        redirect_o         = 1'b0;
        redirect_pc_o      = '0;
        busy_o             = 1'b0;
        unique case (state_q)
            TRAP: begin
                interrupt_type_o   = 1'b1;
                cause_we_o         = 1'b1;
                cause_o            = cause_q;
                epc_we_o           = 1'b1;
                epc_o              = pc_q;
                mstatus_ie_clear_o = 1'b1;
                flush_o            = 1'b1;
                busy_o             = 1'b1;
            end
            JUMP: begin
                redirect_o = 1'b1;
                busy_o     = 1'b1;
`ifdef INTCTRL_VECTORED_EN
                if (mtvec_i[1:0] == 2'b01) begin
                    redirect_pc_o = trap_base + (DATA_WIDTH'(cause_q) << 2);
                end else begin
                    redirect_pc_o = trap_base;
                end
`else
                redirect_pc_o = trap_base;
`endif
            end
            MRET: begin
                mstatus_ie_set_o = 1'b1;
                flush_o          = 1'b1;
                redirect_o       = 1'b1;
                redirect_pc_o    = mepc_i;
                busy_o           = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl: per-cycle vector table plus reset-abort sequence.
module tb_interrupt_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        mstatus_ie_i = 1'b0;
    logic        mie_external_i = 1'b0, mie_timer_i = 1'b0, mie_software_i = 1'b0;
    logic        mip_external_i = 1'b0, mip_timer_i = 1'b0, mip_software_i = 1'b0;
    logic [31:0] mtvec_i = '0, mepc_i = '0, pc_i = '0;
    logic        pc_valid_i = 1'b0, mret_i = 1'b0;
    logic        interrupt_type_o, cause_we_o, epc_we_o;
    logic [3:0]  cause_o;
    logic [31:0] epc_o, redirect_pc_o;
    logic        mstatus_ie_clear_o, mstatus_ie_set_o, flush_o, redirect_o, busy_o;

    int tests = 0;
    int fails = 0;

    interrupt_ctrl #(.DATA_WIDTH(32)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .mstatus_ie_i       (mstatus_ie_i),
        .mie_external_i     (mie_external_i),
        .mie_timer_i        (mie_timer_i),
        .mie_software_i     (mie_software_i),
        .mip_external_i     (mip_external_i),
        .mip_timer_i        (mip_timer_i),
        .mip_software_i     (mip_software_i),
        .mtvec_i            (mtvec_i),
        .mepc_i             (mepc_i),
        .pc_i               (pc_i),
        .pc_valid_i         (pc_valid_i),
        .mret_i             (mret_i),
        .interrupt_type_o   (interrupt_type_o),
        .cause_we_o         (cause_we_o),
        .cause_o            (cause_o),
        .epc_we_o           (epc_we_o),
        .epc_o              (epc_o),
        .mstatus_ie_clear_o (mstatus_ie_clear_o),
        .mstatus_ie_set_o   (mstatus_ie_set_o),
        .flush_o            (flush_o),
        .redirect_o         (redirect_o),
        .redirect_pc_o      (redirect_pc_o),
        .busy_o             (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Packed outputs: {type, cause_we, cause, epc_we, epc, ie_clr, ie_set, flush, redirect, rpc, busy}
    typedef struct {
        string       name;
        logic        ie;
        logic [2:0]  en;    // {ext, tim, sw}
        logic [2:0]  pend;  // {ext, tim, sw}
        logic        pcv;
        logic        mret;
        logic [31:0] pc;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic [75:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [75:0] o_idle();
        return '0;
    endfunction

    function automatic logic [75:0] o_trap(input logic [3:0] c, input logic [31:0] e);
        return {1'b1, 1'b1, c, 1'b1, e, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1};
    endfunction

    function automatic logic [75:0] o_jump(input logic [31:0] r);
        return {1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, r, 1'b1};
    endfunction

    function automatic logic [75:0] o_mret(input logic [31:0] r);
        return {1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, r, 1'b1};
    endfunction

    task automatic add(input string n, input logic ie, input logic [2:0] en, input logic [2:0] pend,
                       input logic pcv, input logic mret, input logic [31:0] pc,
                       input logic [31:0] mtvec, input logic [31:0] mepc, input logic [75:0] exp);
        vec_t v;
        v.name = n; v.ie = ie; v.en = en; v.pend = pend; v.pcv = pcv; v.mret = mret;
        v.pc = pc; v.mtvec = mtvec; v.mepc = mepc; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [75:0] exp);
        logic [75:0] act;
        act = {interrupt_type_o, cause_we_o, cause_o, epc_we_o, epc_o, mstatus_ie_clear_o,
               mstatus_ie_set_o, flush_o, redirect_o, redirect_pc_o, busy_o};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        mstatus_ie_i   = v.ie;
        mie_external_i = v.en[2];
        mie_timer_i    = v.en[1];
        mie_software_i = v.en[0];
        mip_external_i = v.pend[2];
        mip_timer_i    = v.pend[1];
        mip_software_i = v.pend[0];
        pc_valid_i     = v.pcv;
        mret_i         = v.mret;
        pc_i           = v.pc;
        mtvec_i        = v.mtvec;
        mepc_i         = v.mepc;
    endtask

    logic [31:0] vec_rpc;

    initial begin
`ifdef INTCTRL_VECTORED_EN
        vec_rpc = 32'h0000_802C;
`else
        vec_rpc = 32'h0000_8000;
`endif
        add("idle",           0, 3'b000, 3'b000, 1, 0, 32'h0,   32'h8000, 32'h0,    o_idle());
        add("timer_trap",     1, 3'b010, 3'b010, 1, 0, 32'h100, 32'h8000, 32'h0,    o_trap(4'd7, 32'h100));
        add("timer_jump",     0, 3'b010, 3'b010, 1, 0, 32'h100, 32'h8000, 32'h0,    o_jump(32'h8000));
        add("gate_mie0",      0, 3'b010, 3'b010, 1, 0, 32'h104, 32'h8000, 32'h0,    o_idle());
        add("gate_pcv0",      1, 3'b010, 3'b010, 0, 0, 32'h104, 32'h8000, 32'h0,    o_idle());
        add("gate_release",   1, 3'b010, 3'b010, 1, 0, 32'h104, 32'h8000, 32'h0,    o_trap(4'd7, 32'h104));
        add("gate_jump",      0, 3'b010, 3'b010, 1, 0, 32'h104, 32'h8000, 32'h0,    o_jump(32'h8000));
        add("idle2",          0, 3'b000, 3'b000, 0, 0, 32'h0,   32'h8000, 32'h0,    o_idle());
        add("prio_ext",       1, 3'b111, 3'b111, 1, 0, 32'h200, 32'h8001, 32'h0,    o_trap(4'd11, 32'h200));
        add("prio_ext_jump",  0, 3'b111, 3'b111, 1, 0, 32'h200, 32'h8001, 32'h0,    o_jump(vec_rpc));
        add("idle3",          0, 3'b000, 3'b000, 0, 0, 32'h0,   32'h8000, 32'h0,    o_idle());
        add("prio_sw",        1, 3'b011, 3'b111, 1, 0, 32'h300, 32'h8000, 32'h0,    o_trap(4'd3, 32'h300));
        add("drop_keep_jump", 0, 3'b000, 3'b000, 0, 0, 32'h0,   32'h8000, 32'h0,    o_jump(32'h8000));
        add("idle4",          0, 3'b000, 3'b000, 0, 0, 32'h0,   32'h8000, 32'h0,    o_idle());
        add("mret",           0, 3'b000, 3'b000, 1, 1, 32'h500, 32'h8000, 32'h2040, o_mret(32'h2040));
        add("ignored_in_mret",1, 3'b010, 3'b010, 1, 1, 32'h600, 32'h8000, 32'h2040, o_idle());
        add("irq_beats_mret", 1, 3'b010, 3'b010, 1, 1, 32'h600, 32'h8000, 32'h2040, o_trap(4'd7, 32'h600));
        add("irq_mret_jump",  0, 3'b000, 3'b000, 1, 0, 32'h600, 32'h8000, 32'h2040, o_jump(32'h8000));
        add("idle5",          0, 3'b000, 3'b000, 0, 0, 32'h0,   32'h8000, 32'h2040, o_idle());
        add("mret_pcv0",      0, 3'b000, 3'b000, 0, 1, 32'h700, 32'h8000, 32'h2040, o_idle());

        #2 check("reset_state", o_idle());
        @(negedge clk_i);
        rst_i = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk_i);
            #1 check(vecs[i].name, vecs[i].exp);
        end

        // Reset asserted mid-TRAP must clear outputs at once and suppress the JUMP.
        mstatus_ie_i = 1'b1; mie_timer_i = 1'b1; mip_timer_i = 1'b1;
        mie_external_i = 1'b0; mip_external_i = 1'b0; mie_software_i = 1'b0; mip_software_i = 1'b0;
        pc_valid_i = 1'b1; mret_i = 1'b0; pc_i = 32'h900; mtvec_i = 32'h8000;
        @(posedge clk_i);
        #1 check("rst_pre_trap", o_trap(4'd7, 32'h900));
        mstatus_ie_i = 1'b0;
        #2 rst_i = 1'b1;
        #1 check("rst_async_clear", o_idle());
        #1 rst_i = 1'b0;
        @(posedge clk_i);
        #1 check("rst_no_jump", o_idle());
        @(posedge clk_i);
        #1 check("rst_stay_idle", o_idle());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/interrupt_ctrl.md
Name: interrupt_ctrl

Overview:
- Machine-mode interrupt sequencer between the CSR file and the pipeline control.
- Consumes the enable, pending, mtvec and mepc state exported by the CSR file, arbitrates the pending interrupts and takes traps.
- Drives the CSR file's cause, epc and mstatus.MIE update strobes.
- Issues flush and PC-redirect to fetch for both trap entry and mret return.

Parameters:
- DATA_WIDTH, 32, width of PC, mtvec, mepc.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- mstatus_ie_i  in  1  mstatus.MIE from CSR file
- mie_external_i, mie_timer_i, mie_software_i  in  1 each  mie bits 11/7/3
- mip_external_i, mip_timer_i, mip_software_i  in  1 each  pending bits 11/7/3
- mtvec_i  in  DATA_WIDTH  trap vector CSR
- mepc_i  in  DATA_WIDTH  return address CSR
- pc_i  in  DATA_WIDTH  PC of oldest unretired instruction (resume point)
- pc_valid_i  in  1  pc_i names a real instruction (not a bubble)
- mret_i  in  1  mret present at pc_i
- interrupt_type_o  out  1  1 = interrupt cause (mcause MSB)
- cause_we_o  out  1  mcause write strobe
- cause_o  out  4  exception code
- epc_we_o  out  1  mepc write strobe
- epc_o  out  DATA_WIDTH  value for mepc
- mstatus_ie_clear_o  out  1  clear MIE (trap entry)
- mstatus_ie_set_o  out  1  set MIE (mret)
- flush_o  out  1  kill all in-flight instructions
- redirect_o  out  1  load fetch PC with redirect_pc_o
- redirect_pc_o  out  DATA_WIDTH  new fetch PC
- busy_o  out  1  sequence in progress; fetch must hold

Behaviour:
- Reset (async, rst_i=1): state IDLE; captured cause and PC registers cleared; every output 0. Asserting rst_i mid-sequence aborts it immediately with no further strobes.
- Qualified pending: ext = mip_external_i & mie_external_i; sw = mip_software_i & mie_software_i; tim = mip_timer_i & mie_timer_i.
- take_irq = mstatus_ie_i & pc_valid_i & (ext | sw | tim).
- Priority is fixed: external (11) > software (3) > timer (7). The winning code is captured on the accepting edge.
- States: IDLE, TRAP, JUMP, MRET. All outputs decode from state and captured registers only (Moore); no input-to-output combinational path.
- IDLE:
  - take_irq -> TRAP; capture cause and pc_i.
  - else mret_i & pc_valid_i -> MRET.
  - Interrupt wins over a simultaneous mret; the saved epc is the mret's PC, so mret re-executes after the handler.
- TRAP (1 cycle):
  - cause_we_o=1, interrupt_type_o=1, cause_o=captured code.
  - epc_we_o=1, epc_o=captured PC.
  - mstatus_ie_clear_o=1, flush_o=1, busy_o=1.
  - Always -> JUMP.
- JUMP (1 cycle):
  - redirect_o=1, redirect_pc_o={mtvec_i[DATA_WIDTH-1:2],2'b00}, busy_o=1.
  - Always -> IDLE.
- MRET (1 cycle):
  - mstatus_ie_set_o=1, flush_o=1, redirect_o=1, redirect_pc_o=mepc_i, busy_o=1.
  - Always -> IDLE.
- Latency: request sampled at edge N; CSR strobes during cycle N+1; redirect during cycle N+2. mret redirect is in cycle N+1.
- Inputs are ignored outside IDLE. A pending bit that drops after capture does not cancel the trap.
- Back-to-back traps: MIE is cleared in TRAP, so no re-trap until software sets MIE. The first IDLE cycle after MRET may accept a new interrupt.
- epc_o carries the full captured PC. Bits [1:0] are forced to 0 by the CSR file.
- Outside the active states, every strobe is 0, and cause_o, epc_o and redirect_pc_o are 0.

Optional Feature:
- INTCTRL_VECTORED_EN defined: in JUMP, if mtvec_i[1:0]==2'b01, redirect_pc_o = base + (cause << 2). Otherwise it is the base.
- Undefined: mode bits are ignored; redirect_pc_o is always the base (direct mode).

Test Plan:
- Timer trap: MIE=1, mie_timer=1, mip_timer=1, pc_i=0x100, mtvec=0x8000 -> next cycle cause_we=1, cause=7, type=1, epc=0x100, ie_clear=1, flush=1; following cycle redirect=1, pc=0x8000; then IDLE.
- Priority: all three pending and enabled -> cause=11. With external masked (mie_external=0) -> cause=3.
- Gating: MIE=0, or pc_valid_i=0, with a pending enabled interrupt -> no strobes, busy_o=0. Set MIE=1 -> trap begins on the next cycle.
- mret: mepc=0x2040, mret_i=1 -> next cycle ie_set=1, flush=1, redirect=1, pc=0x2040. The same stimulus together with a timer interrupt -> TRAP with epc=pc of mret.
- Reset in TRAP (rst_i pulsed mid-cycle) -> all outputs 0 immediately, no JUMP redirect afterwards.
- INTCTRL_VECTORED_EN: mtvec=0x8001, external interrupt -> redirect_pc=0x802C. Without the macro -> 0x8000.
